// File: rtl/regfile_pkg.sv
// Shared widths and the command record carried through the arbiter's issue stage.
package regfile_pkg;

  localparam int DW = 32;
  localparam int AW = 5;

  // tag names the requester that issued the command so its response routes back to it.
  typedef struct packed {
    logic          write;
    logic [AW-1:0] addr1;
    logic [AW-1:0] addr2;
    logic [DW-1:0] wdata;
    logic          tag;
  } cmd_t;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin grant: ptr names the requester that wins when both request.
module rr_arbiter2 (
  input  logic [1:0] req,
  input  logic       ptr,
  output logic [1:0] grant
);

  always_comb begin
    grant    = 2'b00;
    grant[0] = req[0] & (~req[1] | ~ptr);
    grant[1] = req[1] & (~req[0] |  ptr);
  end

endmodule

// File: rtl/regfile_arbiter.sv
// Two-requester register-file front end: round-robin accept, one issue stage
// driving the external register file, one registered response stage.
module regfile_arbiter
  import regfile_pkg::cmd_t;
#(
  parameter int DW = regfile_pkg::DW,
  parameter int AW = regfile_pkg::AW
) (
  input  logic                clk,
  input  logic                rst,
  // Handshake: a command moves when req_valid[i] and req_ready[i] are both high
  // at a rising edge; req_ready is high for at most one requester per cycle.
  input  logic [1:0]          req_valid,
  output logic [1:0]          req_ready,
  input  logic [1:0]          req_write,
  input  logic [1:0][AW-1:0]  req_addr1,
  input  logic [1:0][AW-1:0]  req_addr2,
  input  logic [1:0][DW-1:0]  req_wdata,
  output logic [1:0]          rsp_valid,
  output logic [1:0]          rsp_write,
  output logic [1:0][DW-1:0]  rsp_data1,
  output logic [1:0][DW-1:0]  rsp_data2,
  output logic                rf_write,
  output logic [AW-1:0]       rf_wraddr,
  output logic [AW-1:0]       rf_rdaddr1,
  output logic [AW-1:0]       rf_rdaddr2,
  output logic [DW-1:0]       rf_wrdata,
  input  logic [DW-1:0]       rf_rddata1,
  input  logic [DW-1:0]       rf_rddata2
);

  logic             ptr_q, ptr_d;
  logic             iss_vld_q, iss_vld_d;
  cmd_t             iss_q, iss_d;
  logic [1:0]       rsp_valid_q, rsp_valid_d;
  logic [1:0]       rsp_write_q, rsp_write_d;
  logic [1:0][DW-1:0] rsp_data1_q, rsp_data1_d;
  logic [1:0][DW-1:0] rsp_data2_q, rsp_data2_d;
  logic [1:0]       grant;
  logic             win;
  logic             xfer;

  rr_arbiter2 u_arb (
    .req   (req_valid),
    .ptr   (ptr_q),
    .grant (grant)
  );

  // Accept path: grant is masked during reset so nothing transfers while rst is high.
  always_comb begin
    req_ready = rst ? 2'b00 : grant;
    xfer      = |req_ready;
    win       = req_ready[1];
    ptr_d     = xfer ? ~win : ptr_q;
    iss_vld_d = xfer;
    iss_d       = '0;
    iss_d.write = req_write[win];
    iss_d.addr1 = req_addr1[win];
    iss_d.addr2 = req_addr2[win];
    iss_d.wdata = req_wdata[win];
    iss_d.tag   = win;
  end

  // Register-file drive comes straight from the issue register; unused fields stay 0.
  always_comb begin
    rf_write   = 1'b0;
    rf_wraddr  = '0;
    rf_rdaddr1 = '0;
    rf_rdaddr2 = '0;
    rf_wrdata  = '0;
    if (iss_vld_q) begin
      if (iss_q.write) begin
        rf_write  = 1'b1;
        rf_wraddr = iss_q.addr1;
        rf_wrdata = iss_q.wdata;
      end else begin
        rf_rdaddr1 = iss_q.addr1;
        rf_rdaddr2 = iss_q.addr2;
      end
    end
  end

  // Only the originating requester's response fields update; the rest hold.
  always_comb begin
    rsp_valid_d = 2'b00;
    rsp_write_d = rsp_write_q;
    rsp_data1_d = rsp_data1_q;
    rsp_data2_d = rsp_data2_q;
    if (iss_vld_q) begin
      rsp_valid_d[iss_q.tag] = 1'b1;
      rsp_write_d[iss_q.tag] = iss_q.write;
      rsp_data1_d[iss_q.tag] = iss_q.write ? '0 : rf_rddata1;
      rsp_data2_d[iss_q.tag] = iss_q.write ? '0 : rf_rddata2;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_q       <= 1'b0;
      iss_vld_q   <= 1'b0;
      iss_q       <= '0;
      rsp_valid_q <= 2'b00;
      rsp_write_q <= 2'b00;
      rsp_data1_q <= '0;
      rsp_data2_q <= '0;
    end else begin
      ptr_q       <= ptr_d;
      iss_vld_q   <= iss_vld_d;
      iss_q       <= iss_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_write_q <= rsp_write_d;
      rsp_data1_q <= rsp_data1_d;
      rsp_data2_q <= rsp_data2_d;
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_write = rsp_write_q;
  assign rsp_data1 = rsp_data1_q;
  assign rsp_data2 = rsp_data2_q;

endmodule

// File: tb/tb_regfile_arbiter.sv
// Directed bench for regfile_arbiter with a behavioural register file and a
// response scoreboard fed by the driver and drained by an independent monitor.
module tb_regfile_arbiter;
  import regfile_pkg::*;

  localparam int EW = 32 + 1 + 1 + DW + DW;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [1:0]          req_valid, req_ready, req_write;
  logic [1:0][AW-1:0]  req_addr1, req_addr2;
  logic [1:0][DW-1:0]  req_wdata;
  logic [1:0]          rsp_valid, rsp_write;
  logic [1:0][DW-1:0]  rsp_data1, rsp_data2;
  logic                rf_write;
  logic [AW-1:0]       rf_wraddr, rf_rdaddr1, rf_rdaddr2;
  logic [DW-1:0]       rf_wrdata, rf_rddata1, rf_rddata2;

  regfile_arbiter #(.DW(DW), .AW(AW)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr1(req_addr1), .req_addr2(req_addr2), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_write(rsp_write),
    .rsp_data1(rsp_data1), .rsp_data2(rsp_data2),
    .rf_write(rf_write), .rf_wraddr(rf_wraddr),
    .rf_rdaddr1(rf_rdaddr1), .rf_rdaddr2(rf_rdaddr2), .rf_wrdata(rf_wrdata),
    .rf_rddata1(rf_rddata1), .rf_rddata2(rf_rddata2)
  );

  // External register file: combinational read, forced to 0 during a write.
  logic [DW-1:0] rf_mem [32];
  always_comb begin
    rf_rddata1 = rf_write ? '0 : rf_mem[rf_rdaddr1];
    rf_rddata2 = rf_write ? '0 : rf_mem[rf_rdaddr2];
  end
  always @(posedge clk) if (rf_write) rf_mem[rf_wraddr] <= rf_wrdata;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail   = 0;
  logic [EW-1:0] exp_q[$];
  logic [DW-1:0] model [32];
  logic prev_v;
  cmd_t prev;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic cmd_t wr(input logic [AW-1:0] a, input logic [DW-1:0] d);
    cmd_t c;
    c = '0; c.write = 1'b1; c.addr1 = a; c.wdata = d;
    return c;
  endfunction

  function automatic cmd_t rd(input logic [AW-1:0] a1, input logic [AW-1:0] a2);
    cmd_t c;
    c = '0; c.addr1 = a1; c.addr2 = a2;
    return c;
  endfunction

  // Drive one cycle of requests, check grant and the rf drive of the previous accept,
  // and queue the expected response of whichever requester should win.
  task automatic cycle(input logic [1:0] v, input cmd_t c0, input cmd_t c1,
                       input logic [1:0] exp_gnt, input bit discard);
    cmd_t c;
    logic [47:0] rf_exp;
    logic [31:0] ce;
    req_valid    = v;
    req_write    = {c1.write, c0.write};
    req_addr1[0] = c0.addr1; req_addr1[1] = c1.addr1;
    req_addr2[0] = c0.addr2; req_addr2[1] = c1.addr2;
    req_wdata[0] = c0.wdata; req_wdata[1] = c1.wdata;
    @(negedge clk);
    check("req_ready", 64'(req_ready), 64'(exp_gnt));
    if (!prev_v)         rf_exp = '0;
    else if (prev.write) rf_exp = {1'b1, prev.addr1, 5'd0, 5'd0, prev.wdata};
    else                 rf_exp = {1'b0, 5'd0, prev.addr1, prev.addr2, 32'd0};
    check("rf_outputs", 64'({rf_write, rf_wraddr, rf_rdaddr1, rf_rdaddr2, rf_wrdata}), 64'(rf_exp));
    prev_v = 1'b0;
    if (exp_gnt != 2'b00) begin
      c = exp_gnt[1] ? c1 : c0;
      prev_v = 1'b1;
      prev   = c;
      if (!discard) begin
        ce = 32'(cyc + 2);
        exp_q.push_back({ce, exp_gnt[1], c.write,
                         c.write ? 32'd0 : model[c.addr1],
                         c.write ? 32'd0 : model[c.addr2]});
        if (c.write) model[c.addr1] = c.wdata;
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_req_ready"}, 64'(req_ready), 64'd0);
    check({tag, "_rf_outputs"}, 64'({rf_write, rf_wraddr, rf_rdaddr1, rf_rdaddr2, rf_wrdata}), 64'd0);
    check({tag, "_rsp_valid"}, 64'(rsp_valid), 64'd0);
    check({tag, "_rsp_write"}, 64'(rsp_write), 64'd0);
    check({tag, "_rsp_data1"}, 64'(rsp_data1), 64'd0);
    check({tag, "_rsp_data2"}, 64'(rsp_data2), 64'd0);
  endtask

  // Monitor: every response strobe must match the oldest outstanding expectation.
  always @(negedge clk) begin
    logic [EW-1:0] e;
    logic t;
    if (rsp_valid != 2'b00) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_rsp: got rsp_valid=%b expected none (cycle %0d)", rsp_valid, cyc);
      end else begin
        e = exp_q.pop_front();
        t = e[2*DW+1];
        check("rsp_valid", 64'(rsp_valid), t ? 64'd2 : 64'd1);
        check("rsp_cycle", 64'(cyc), 64'(e[EW-1 -: 32]));
        check("rsp_write", 64'(rsp_write[t]), 64'(e[2*DW]));
        check("rsp_data1", 64'(rsp_data1[t]), 64'(e[2*DW-1 -: DW]));
        check("rsp_data2", 64'(rsp_data2[t]), 64'(e[DW-1:0]));
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    cmd_t nop;
    nop = '0;
    for (int i = 0; i < 32; i++) begin
      rf_mem[i] <= (i == 0) ? 32'h5A5A_0000 : (i == 7) ? 32'h1 : 32'hA000_0000 + i;
      model[i]   = (i == 0) ? 32'h5A5A_0000 : (i == 7) ? 32'h1 : 32'hA000_0000 + i;
    end
    rst = 1'b1;
    req_valid = 2'b11; req_write = '0;
    req_addr1 = '0; req_addr2 = '0; req_wdata = '0;
    prev_v = 1'b0; prev = '0;
    @(negedge clk);
    check_reset_state("reset");
    @(posedge clk); #1;
    rst = 1'b0;

    // Write from requester 0, then requester 1 reads it back.
    cycle(2'b01, wr(5'd3, 32'hDEAD_BEEF), nop, 2'b01, 1'b0);
    cycle(2'b10, nop, rd(5'd3, 5'd0), 2'b10, 1'b0);

    // Sustained contention alternates grants starting with requester 0.
    for (int i = 0; i < 6; i++)
      cycle(2'b11, rd(5'(i), 5'd3), wr(5'(20 + i), 32'hC0DE_0000 + i),
            (i % 2 == 0) ? 2'b01 : 2'b10, 1'b0);

    // Requester 1 alone wins every cycle; pointer ends back at 0.
    for (int i = 0; i < 3; i++)
      cycle(2'b10, nop, rd(5'(20 + i), 5'(21 + i)), 2'b10, 1'b0);
    cycle(2'b11, rd(5'd22, 5'd23), rd(5'd24, 5'd25), 2'b01, 1'b0);
    for (int i = 0; i < 3; i++) cycle(2'b00, nop, nop, 2'b00, 1'b0);

    // Reset during the issue cycle of a write to 7 must drop it.
    cycle(2'b01, wr(5'd7, 32'hABCD_1234), nop, 2'b01, 1'b1);
    rst = 1'b1;
    req_valid = 2'b11;
    @(negedge clk);
    check_reset_state("midreset");
    @(posedge clk); #1;
    rst = 1'b0;
    prev_v = 1'b0;
    cycle(2'b11, rd(5'd7, 5'd3), rd(5'd0, 5'd7), 2'b01, 1'b0);
    cycle(2'b00, nop, nop, 2'b00, 1'b0);

    // Full-rate write/read pairs to one address.
    for (int i = 0; i < 4; i++) begin
      cycle(2'b01, wr(5'd9, 32'h9000_0000 + 32'(i * 17)), nop, 2'b01, 1'b0);
      cycle(2'b10, nop, rd(5'd9, 5'd9), 2'b10, 1'b0);
    end

    for (int i = 0; i < 10 && exp_q.size() != 0; i++)
      cycle(2'b00, nop, nop, 2'b00, 1'b0);
    check("drain_empty", 64'(exp_q.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/regfile_arbiter.md
REGFILE_ARBITER -- requirements
Module: regfile_arbiter

Interface
REQ-001 Parameter DW, 32, data width of the register file.
REQ-002 Parameter AW, 5, register address width (32 entries).
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 req_valid[i] (i=0,1)  input  1  requester i presents a command.
REQ-006 req_ready[i]  output  1  arbiter accepts requester i's command this cycle.
REQ-007 req_write[i]  input  1  1 = write command, 0 = read command.
REQ-008 req_addr1[i], req_addr2[i]  input  AW each  read addresses; req_addr1 doubles as the write address.
REQ-009 req_wdata[i]  input  DW  write data.
REQ-010 rsp_valid[i]  output  1  one-cycle response strobe to requester i.
REQ-011 rsp_write[i]  output  1  response is a write acknowledge (data fields are 0).
REQ-012 rsp_data1[i], rsp_data2[i]  output  DW each  read results.
REQ-013 rf_write  output  1  register-file write enable.
REQ-014 rf_wraddr, rf_rdaddr1, rf_rdaddr2  output  AW each  register-file addresses.
REQ-015 rf_wrdata  output  DW  register-file write data.
REQ-016 rf_rddata1, rf_rddata2  input  DW each  register-file read data; combinational from rf_rdaddr*, forced to 0 while rf_write=1.

Function
REQ-017 Handshake: a command transfers when req_valid[i] and req_ready[i] are both 1 at a rising edge; at most one requester is granted per cycle.
REQ-018 req_ready is combinational from req_valid and the priority pointer; req_ready[i]=1 only for the single granted requester.
REQ-019 Arbitration: round-robin over 2 requesters; with both valid, the requester named by the priority pointer wins; with one valid, it wins regardless of pointer.
REQ-020 The priority pointer moves to the requester other than the winner only on a transfer; it is unchanged in cycles with no transfer.
REQ-021 Stage 1 (issue): a command accepted at edge N is held in an issue register and drives rf_* throughout cycle N+1.
REQ-022 During issue of a write: rf_write=1, rf_wraddr=addr1, rf_wrdata=wdata; rf_rdaddr1/2 = 0.
REQ-023 During issue of a read: rf_write=0, rf_rdaddr1=addr1, rf_rdaddr2=addr2; rf_wraddr=0, rf_wrdata=0.
REQ-024 With no command in issue: rf_write=0 and all rf address/data outputs 0.
REQ-025 Stage 2 (response): at the edge ending issue cycle N+1, rf_rddata1/2 (read) or 0 (write) are registered; rsp_valid of the originating requester is 1 for exactly cycle N+2, others 0.
REQ-026 Latency: accept edge to rsp_valid = 2 cycles; throughput one command per cycle, no bubbles.
REQ-027 Read-after-write: a read accepted the edge after a write to the same address returns the new data.
REQ-028 Responses have no backpressure; requesters always accept rsp_valid.
REQ-029 rsp_data1/2 and rsp_write hold their last value between strobes; only rsp_valid marks validity.
REQ-030 Requester is tracked by a tag in the issue register; responses never route to a non-originating requester.

Reset
REQ-031 While rst=1: priority pointer=0, issue and response stages empty, req_ready=0, rsp_valid=0, rsp_write=0, rsp_data*=0, rf_write=0, rf_* outputs=0.
REQ-032 Reset asserted mid-operation discards in-flight commands; no response is produced for them and no register write completes after rst rises.
REQ-033 First grant after reset release favours requester 0 on contention.

Structure
REQ-034 Shared package regfile_pkg holds DW, AW, and the command record (write, addr1, addr2, wdata, tag).
REQ-035 Round-robin grant logic is sub-module rr_arbiter2 (inputs req[1:0], pointer; outputs grant[1:0]); the pointer register lives in regfile_arbiter.
REQ-036 The register file is instantiated outside this block; it connects only via rf_*.

Verification
REQ-037 Reset release, req_valid[0]=1 write addr1=3 wdata=0xDEADBEEF -> req_ready[0]=1, next cycle rf_write=1 rf_wraddr=3, two cycles after accept rsp_valid[0]=1 rsp_write=1.
REQ-038 Requester 1 read addr1=3 addr2=0 on the cycle after the above write -> rsp_valid[1]=1, rsp_data1=0xDEADBEEF, rsp_data2=register 0 contents.
REQ-039 Both req_valid held 1 for 6 cycles -> grants alternate 0,1,0,1,0,1; six responses in order, one per cycle.
REQ-040 req_valid[1] only, for 3 cycles with pointer at 0 -> requester 1 granted each cycle; pointer finally at 0.
REQ-041 rst pulsed during issue cycle of a write to addr 7 (prior value 0x1) -> no rsp_valid; later read of 7 returns 0x1.
REQ-042 Back-to-back alternating write/read to same address at full rate -> every read returns the immediately preceding write's data.
